load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// encodings, error codes and the default memory timeout.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_FUNCT3   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    // Unsigned widths exist only for loads; stores accept B/H/W.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] byte_off);
        logic bad;
        bad = 1'b0;
        case (f3[1:0])
            2'b01:   bad = byte_off[0];
            2'b10:   bad = (byte_off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication / byte enables and
// load byte/halfword selection with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wdata = store_data;
        wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << byte_off;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << {byte_off[1], 1'b0};
            end
            default: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_ext = {24'd0, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_ext = {16'd0, half_sel};
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core memory operation, issues a single
// word-aligned request, waits for ack or timeout, and reports completion.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUout,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic [31:0] loadData,
    output logic [1:0]  errCode,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memWstrb,
    input  logic [31:0] memRdata,
    input  logic        memAck
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state, state_next;
    lsu_err_e    err_q, err_next;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [2:0]  f3_q;
    logic        store_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] load_q;

    logic        op_valid;
    logic        accept;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_load;

    assign op_valid = memRead ^ memWrite;
    assign accept   = (state == ST_IDLE) && start && op_valid;

    lsu_align u_align (
        .funct3     (f3_q),
        .byte_off   (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (memRdata),
        .wdata      (lane_wdata),
        .wstrb      (lane_wstrb),
        .load_ext   (lane_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_next   = err_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!f3_legal(funct3, memWrite)) begin
                        state_next = ST_DONE;
                        err_next   = ERR_FUNCT3;
                    end else if (misaligned(funct3, ALUout[1:0])) begin
                        state_next = ST_DONE;
                        err_next   = ERR_MISALIGN;
                    end else begin
                        state_next = ST_REQ;
                        err_next   = ERR_NONE;
                    end
                end
            end
            ST_REQ: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (memAck) begin
                    state_next = ST_DONE;
                    err_next   = ERR_NONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_next = ST_DONE;
                    err_next   = ERR_TIMEOUT;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = accept || (state == ST_REQ);
        done     = (state == ST_DONE);
        errCode  = (state == ST_DONE) ? err_q : ERR_NONE;
        memReq   = (state == ST_REQ);
        memWe    = (state == ST_REQ) && store_q;
        memAddr  = (state == ST_REQ) ? {addr_q[31:2], 2'b00} : '0;
        memWdata = memWe ? lane_wdata : '0;
        memWstrb = memWe ? lane_wstrb : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= ERR_NONE;
            addr_q  <= '0;
            sdata_q <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            cnt_q   <= '0;
            load_q  <= '0;
        end else begin
            err_q <= err_next;
            if (accept) begin
                addr_q  <= ALUout;
                sdata_q <= storeData;
                f3_q    <= funct3;
                store_q <= memWrite;
            end
            if (state == ST_REQ) cnt_q <= cnt_q + 1'b1;
            else                 cnt_q <= '0;
            if ((state == ST_REQ) && memAck && !store_q) load_q <= lane_load;
        end
    end

    assign loadData = load_q;

endmodule
